psu_cwdarr_seq: RTL and testbench

PSU_CWDARR_SEQ -- requirements
Module: psu_cwdarr_seq

---
 rtl/psu_cwdarr_seq_pkg.sv | 19 +
 rtl/psu_cwdarr_seq_cwdsel.sv | 24 ++
 rtl/psu_cwdarr_seq.sv | 97 +++++++++
 tb/tb_psu_cwdarr_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psu_cwdarr_seq_pkg.sv
// Shared constants, default widths and type definitions for the codeword-array sequencer.
package psu_cwdarr_seq_pkg;

  localparam int CWD_I       = 0;
  localparam int DEF_NUM_PQ  = 16;
  localparam int DEF_CWD_BW  = 4;
  localparam int DEF_NUM_CLS = 4;
  localparam int DEF_REP_BW  = 4;

  // Class encoding: the ordinary gate codeword and the special-case codeword.
  localparam int CLS_NORMAL  = 0;
  localparam int CLS_SPECIAL = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/psu_cwdarr_seq_cwdsel.sv
// One qubit's codeword selector: class lookup into the codeword table, idle codeword when masked off.
module psu_cwdsel
  import psu_cwdarr_seq_pkg::*;
#(
  parameter int                CWD_BW   = DEF_CWD_BW,
  parameter int                NUM_CLS  = DEF_NUM_CLS,
  parameter int                CLS_BW   = $clog2(NUM_CLS),
  parameter logic [CWD_BW-1:0] CWD_IDLE = CWD_BW'(CWD_I)
) (
  input  logic                      mask_i,
  input  logic [CLS_BW-1:0]         cls_i,
  input  logic [NUM_CLS*CWD_BW-1:0] table_i,
  output logic [CWD_BW-1:0]         cwd_o
);

  logic [CWD_BW-1:0] tab [NUM_CLS];

  for (genvar gi = 0; gi < NUM_CLS; gi++) begin : g_tab
    assign tab[gi] = table_i[gi*CWD_BW +: CWD_BW];
  end

  assign cwd_o = mask_i ? tab[cls_i] : CWD_IDLE;

endmodule

// File: rtl/psu_cwdarr_seq.sv
// Registers a per-qubit codeword array on accept and replays it rep+1 times over a valid/ready stream.
module psu_cwdarr_seq
  import psu_cwdarr_seq_pkg::*;
#(
  parameter int NUM_PQ   = DEF_NUM_PQ,
  parameter int CWD_BW   = DEF_CWD_BW,
  parameter int NUM_CLS  = DEF_NUM_CLS,
  parameter int REP_BW   = DEF_REP_BW,
  parameter int CWD_IDLE = CWD_I
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_PQ-1:0]                mask_ext_array,
  input  logic [NUM_PQ*$clog2(NUM_CLS)-1:0] cls_ext_array,
  input  logic [NUM_CLS*CWD_BW-1:0]        cwd_table,
  input  logic [REP_BW-1:0]                rep,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_PQ*CWD_BW-1:0]         cwdarray,
  output logic                             out_last
);

  localparam int                       CLS_BW   = $clog2(NUM_CLS);
  localparam logic [CWD_BW-1:0]        IDLE_CWD = CWD_BW'(CWD_IDLE);
  localparam logic [NUM_PQ*CWD_BW-1:0] IDLE_ARR = {NUM_PQ{IDLE_CWD}};

  state_e                     state_q, state_d;
  logic [REP_BW-1:0]          cnt_q, cnt_d;
  logic [NUM_PQ*CWD_BW-1:0]   arr_q, arr_d;
  logic [NUM_PQ*CWD_BW-1:0]   sel_arr;
  logic                       accept, fire;

  for (genvar gi = 0; gi < NUM_PQ; gi++) begin : g_sel
    psu_cwdsel #(
      .CWD_BW   (CWD_BW),
      .NUM_CLS  (NUM_CLS),
      .CLS_BW   (CLS_BW),
      .CWD_IDLE (IDLE_CWD)
    ) u_sel (
      .mask_i  (mask_ext_array[gi]),
      .cls_i   (cls_ext_array[gi*CLS_BW +: CLS_BW]),
      .table_i (cwd_table),
      .cwd_o   (sel_arr[gi*CWD_BW +: CWD_BW])
    );
  end

  assign accept   = in_valid & in_ready;
  assign fire     = out_valid & out_ready;
  assign cwdarray = arr_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EMIT;
      ST_EMIT: if (fire && out_last && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // in_ready opens on the final handshake so a new request follows with no bubble.
  always_comb begin
    out_valid = (state_q == ST_EMIT);
    out_last  = out_valid && (cnt_q == '0);
    in_ready  = (state_q == ST_IDLE) || (out_valid && out_ready && out_last);
  end

  // The array returns to idle after the final beat so it reads idle whenever out_valid is low.
  always_comb begin
    cnt_d = cnt_q;
    arr_d = arr_q;
    if (accept) begin
      cnt_d = rep;
      arr_d = sel_arr;
    end else if (fire) begin
      if (out_last) arr_d = IDLE_ARR;
      else          cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      arr_q <= IDLE_ARR;
    end else begin
      cnt_q <= cnt_d;
      arr_q <= arr_d;
    end
  end

endmodule

// File: tb/tb_psu_cwdarr_seq.sv
// Directed bench for psu_cwdarr_seq: vector table of single-beat requests plus multi-cycle sequences.
module tb_psu_cwdarr_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  mask_ext_array;
  logic [7:0]  cls_ext_array;
  logic [11:0] cwd_table;
  logic [3:0]  rep;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] cwdarray;
  logic        out_last;

  int n_pass;
  int n_total;

  psu_cwdarr_seq #(
    .NUM_PQ   (4),
    .CWD_BW   (3),
    .NUM_CLS  (4),
    .REP_BW   (4),
    .CWD_IDLE (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mask_ext_array (mask_ext_array),
    .cls_ext_array  (cls_ext_array),
    .cwd_table      (cwd_table),
    .rep            (rep),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .cwdarray       (cwdarray),
    .out_last       (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [7:0]  cls;
    logic [11:0] tbl;
    logic [11:0] exp_arr;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
      $display("check %s: got %0h expected %0h ok", name, act, req);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [3:0] r);
    mask_ext_array = vecs[idx].mask;
    cls_ext_array  = vecs[idx].cls;
    cwd_table      = vecs[idx].tbl;
    rep            = r;
  endtask

  initial begin
    logic rp [4];
    logic el [4];
    int   hs;
    int   beats;
    int   lasts;
    int   last_at;

    // Class fields listed q3..q0, table entries k3..k0, expected codewords q3..q0.
    vecs[0] = '{4'b1011, {2'd1, 2'd0, 2'd2, 2'd0}, {3'd7, 3'd3, 3'd6, 3'd5}, {3'd6, 3'd0, 3'd3, 3'd5}};
    vecs[1] = '{4'b1111, {2'd3, 2'd3, 2'd3, 2'd3}, {3'd7, 3'd3, 3'd6, 3'd5}, {3'd7, 3'd7, 3'd7, 3'd7}};
    vecs[2] = '{4'b0000, {2'd1, 2'd2, 2'd3, 2'd1}, {3'd7, 3'd3, 3'd6, 3'd5}, {3'd0, 3'd0, 3'd0, 3'd0}};
    vecs[3] = '{4'b0101, {2'd3, 2'd1, 2'd0, 2'd2}, {3'd1, 3'd2, 3'd4, 3'd6}, {3'd0, 3'd4, 3'd0, 3'd2}};
    vecs[4] = '{4'b1110, {2'd0, 2'd1, 2'd2, 2'd3}, {3'd3, 3'd2, 3'd1, 3'd5}, {3'd5, 3'd1, 3'd2, 3'd0}};

    n_pass = 0;
    n_total = 0;
    clk = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    mask_ext_array = '0;
    cls_ext_array = '0;
    cwd_table = '0;
    rep = '0;
    out_ready = 1'b0;

    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_cwdarray", 32'(cwdarray), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single-beat requests; inputs are scrambled right after accept to prove sampling.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      load(i, 4'd0);
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_idle_ready", i), 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      mask_ext_array = ~vecs[i].mask;
      cwd_table = ~vecs[i].tbl;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_last", i), 32'(out_last), 32'd1);
      chk($sformatf("v%0d_arr", i), 32'(cwdarray), 32'(vecs[i].exp_arr));
      chk($sformatf("v%0d_ready_on_last", i), 32'(in_ready), 32'd1);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_after_valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_after_arr", i), 32'(cwdarray), 32'd0);
    end

    // rep=2 with a stall on the second cycle.
    rp = '{1'b1, 1'b0, 1'b1, 1'b1};
    el = '{1'b0, 1'b0, 1'b0, 1'b1};
    hs = 0;
    tick();
    load(0, 4'd2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      out_ready = rp[k];
      @(negedge clk);
      chk($sformatf("rep2_c%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("rep2_c%0d_arr", k), 32'(cwdarray), 32'(vecs[0].exp_arr));
      chk($sformatf("rep2_c%0d_last", k), 32'(out_last), 32'(el[k]));
      if (out_valid && out_ready) hs++;
      tick();
    end
    @(negedge clk);
    chk("rep2_done_valid", 32'(out_valid), 32'd0);
    chk("rep2_handshakes", 32'(hs), 32'd3);

    // Back-to-back requests with in_valid held high.
    tick();
    load(0, 4'd0);
    in_valid = 1'b1;
    tick();
    load(1, 4'd0);
    @(negedge clk);
    chk("b2b_first_valid", 32'(out_valid), 32'd1);
    chk("b2b_first_arr", 32'(cwdarray), 32'(vecs[0].exp_arr));
    chk("b2b_first_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_valid", 32'(out_valid), 32'd1);
    chk("b2b_second_arr", 32'(cwdarray), 32'(vecs[1].exp_arr));
    chk("b2b_second_last", 32'(out_last), 32'd1);
    tick();
    @(negedge clk);
    chk("b2b_done_valid", 32'(out_valid), 32'd0);

    // Reset during beat 2 of a rep=3 request.
    tick();
    load(0, 4'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_beat1_valid", 32'(out_valid), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_beat2_valid", 32'(out_valid), 32'd1);
    chk("rstmid_beat2_last", 32'(out_last), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", 32'(out_valid), 32'd0);
    chk("rstmid_arr", 32'(cwdarray), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_last", 32'(out_last), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("rstmid_quiet%0d", k), 32'(out_valid), 32'd0);
    end

    // Table and mask change one cycle after accept must not reach in-flight beats.
    tick();
    load(0, 4'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cwd_table = 12'h000;
    mask_ext_array = 4'b0100;
    @(negedge clk);
    chk("hold_b1_arr", 32'(cwdarray), 32'(vecs[0].exp_arr));
    chk("hold_b1_last", 32'(out_last), 32'd0);
    tick();
    @(negedge clk);
    chk("hold_b2_arr", 32'(cwdarray), 32'(vecs[0].exp_arr));
    chk("hold_b2_last", 32'(out_last), 32'd1);
    tick();
    @(negedge clk);
    chk("hold_done_valid", 32'(out_valid), 32'd0);

    // Maximum repeat count: 16 beats, out_last only on the final one.
    tick();
    load(3, 4'd15);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beats = 0;
    lasts = 0;
    last_at = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!out_valid) break;
      beats++;
      if (out_last) begin
        lasts++;
        last_at = beats;
      end
      tick();
    end
    chk("repmax_beats", 32'(beats), 32'd16);
    chk("repmax_last_count", 32'(lasts), 32'd1);
    chk("repmax_last_at", 32'(last_at), 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
